// File: rtl/argmax_pkg.sv
// Shared types and compare helpers for the streaming argmax block.
package argmax_pkg;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    localparam int MAX_W = 64;

    // Operands are left-aligned so the sign bit of a w-bit value lands on bit 63.
    function automatic logic gt(input logic [MAX_W-1:0] a,
                                input logic [MAX_W-1:0] b,
                                input logic             signed_mode,
                                input int               w = MAX_W);
        logic [MAX_W-1:0] a_al;
        logic [MAX_W-1:0] b_al;
        logic             res;
        a_al = a << (MAX_W - w);
        b_al = b << (MAX_W - w);
        if (signed_mode) begin
            res = $signed(a_al) > $signed(b_al);
        end else begin
            res = a_al > b_al;
        end
        return res;
    endfunction

    function automatic logic [MAX_W-1:0] min_val(input int w, input logic signed_mode);
        logic [MAX_W-1:0] v;
        v = {MAX_W{1'b0}};
        if (signed_mode) begin
            v[w-1] = 1'b1;
        end else begin
            v = {MAX_W{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/argmax_cmp_upd.sv
// Combinational compare/update cell: keeps the current best or takes the beat.
module argmax_cmp_upd
    import argmax_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int IDX_W      = 4,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic [DATA_W-1:0] cur_val,
    input  logic [IDX_W-1:0]  cur_idx,
    input  logic [DATA_W-1:0] beat_val,
    input  logic [IDX_W-1:0]  beat_idx,
    input  logic              load,
    output logic [DATA_W-1:0] nxt_val,
    output logic [IDX_W-1:0]  nxt_idx,
    output logic              take
);

    // Strict compare keeps the earliest index on ties.
    always_comb begin
        take = load | gt(MAX_W'(beat_val), MAX_W'(cur_val), SIGNED_CMP, DATA_W);
        if (take) begin
            nxt_val = beat_val;
            nxt_idx = beat_idx;
        end else begin
            nxt_val = cur_val;
            nxt_idx = cur_idx;
        end
    end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over N_CLASS scores per frame with a registered result handshake.
// Define ARGMAX_TOP2_EN to also report the second-highest score and its index.
module argmax_stream
    import argmax_pkg::*;
#(
    parameter int   N_CLASS    = 10,
    parameter int   DATA_W     = 16,
    parameter bit   SIGNED_CMP = 1'b0,
    localparam int  IDX_W      = $clog2(N_CLASS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_value,
    output logic [IDX_W-1:0]  out_index,
`ifdef ARGMAX_TOP2_EN
    output logic [DATA_W-1:0] out_value2,
    output logic [IDX_W-1:0]  out_index2,
`endif
    output logic              out_err
);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [IDX_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   max_r;
    logic [IDX_W-1:0]    idx_r;
    logic [DATA_W-1:0]   max_nxt_s;
    logic [IDX_W-1:0]    idx_nxt_s;
    logic                max_take_s;
    logic                accept_s;
    logic                last_beat_s;
    logic                frame_end_s;
    logic                hs_s;

    assign in_ready    = !rst && (state_r == S_ACC);
    assign accept_s    = in_valid && in_ready;
    assign last_beat_s = (cnt_r == IDX_W'(N_CLASS - 1));
    assign frame_end_s = accept_s && (in_last || last_beat_s);
    assign hs_s        = out_valid && out_ready;

    argmax_cmp_upd #(.DATA_W(DATA_W), .IDX_W(IDX_W), .SIGNED_CMP(SIGNED_CMP)) u_max (
        .cur_val  (max_r),
        .cur_idx  (idx_r),
        .beat_val (in_data),
        .beat_idx (cnt_r),
        .load     (cnt_r == {IDX_W{1'b0}}),
        .nxt_val  (max_nxt_s),
        .nxt_idx  (idx_nxt_s),
        .take     (max_take_s)
    );

`ifdef ARGMAX_TOP2_EN
    logic [DATA_W-1:0] max2_r;
    logic [IDX_W-1:0]  idx2_r;
    logic [DATA_W-1:0] sec_cmp_val_s;
    logic [IDX_W-1:0]  sec_cmp_idx_s;
    logic              sec_take_s;
    logic [DATA_W-1:0] sec_nxt_val_s;
    logic [IDX_W-1:0]  sec_nxt_idx_s;

    argmax_cmp_upd #(.DATA_W(DATA_W), .IDX_W(IDX_W), .SIGNED_CMP(SIGNED_CMP)) u_sec (
        .cur_val  (max2_r),
        .cur_idx  (idx2_r),
        .beat_val (in_data),
        .beat_idx (cnt_r),
        .load     (1'b0),
        .nxt_val  (sec_cmp_val_s),
        .nxt_idx  (sec_cmp_idx_s),
        .take     (sec_take_s)
    );

    // A displaced maximum becomes the runner-up; otherwise the runner-up competes on its own.
    always_comb begin
        if (cnt_r == {IDX_W{1'b0}}) begin
            sec_nxt_val_s = DATA_W'(min_val(DATA_W, SIGNED_CMP));
            sec_nxt_idx_s = {IDX_W{1'b0}};
        end else if (max_take_s) begin
            sec_nxt_val_s = max_r;
            sec_nxt_idx_s = idx_r;
        end else if (sec_take_s) begin
            sec_nxt_val_s = sec_cmp_val_s;
            sec_nxt_idx_s = sec_cmp_idx_s;
        end else begin
            sec_nxt_val_s = max2_r;
            sec_nxt_idx_s = idx2_r;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_ACC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_ACC: begin
                if (frame_end_s) begin
                    state_nxt_s = S_OUT;
                end else begin
                    state_nxt_s = S_ACC;
                end
            end
            S_OUT: begin
                if (hs_s) begin
                    state_nxt_s = S_ACC;
                end else begin
                    state_nxt_s = S_OUT;
                end
            end
            default: state_nxt_s = S_ACC;
        endcase
    end

    // Running best, beat counter and the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= {IDX_W{1'b0}};
            max_r      <= {DATA_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            out_valid  <= 1'b0;
            out_value  <= {DATA_W{1'b0}};
            out_index  <= {IDX_W{1'b0}};
            out_err    <= 1'b0;
`ifdef ARGMAX_TOP2_EN
            max2_r     <= {DATA_W{1'b0}};
            idx2_r     <= {IDX_W{1'b0}};
            out_value2 <= {DATA_W{1'b0}};
            out_index2 <= {IDX_W{1'b0}};
`endif
        end else if (accept_s) begin
            cnt_r <= cnt_r + IDX_W'(1);
            max_r <= max_nxt_s;
            idx_r <= idx_nxt_s;
`ifdef ARGMAX_TOP2_EN
            max2_r <= sec_nxt_val_s;
            idx2_r <= sec_nxt_idx_s;
`endif
            if (frame_end_s) begin
                out_valid <= 1'b1;
                out_value <= max_nxt_s;
                out_index <= idx_nxt_s;
                out_err   <= in_last ^ last_beat_s;
`ifdef ARGMAX_TOP2_EN
                out_value2 <= sec_nxt_val_s;
                out_index2 <= sec_nxt_idx_s;
`endif
            end else begin
                out_valid <= out_valid;
            end
        end else if (hs_s) begin
            out_valid <= 1'b0;
            cnt_r     <= {IDX_W{1'b0}};
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream: unsigned and signed instances share one stimulus stream.
module tb_argmax_stream;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int IW = 4;

    typedef logic [N-1:0][W-1:0] frame_t;

    typedef struct {
        frame_t      sc;
        int          len;
        bit          last;
        int          hold;
        logic [W-1:0] eu;
        int          iu;
        logic [W-1:0] es;
        int          is_;
        bit          ee;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic [W-1:0]  in_data;

    logic          u_in_ready, s_in_ready, u_out_valid, s_out_valid, u_out_err, s_out_err;
    logic [W-1:0]  u_out_value, s_out_value;
    logic [IW-1:0] u_out_index, s_out_index;
`ifdef ARGMAX_TOP2_EN
    logic [W-1:0]  u_out_value2, s_out_value2;
    logic [IW-1:0] u_out_index2, s_out_index2;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    argmax_stream #(.N_CLASS(N), .DATA_W(W), .SIGNED_CMP(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(u_out_valid),
        .out_ready(out_ready), .out_value(u_out_value), .out_index(u_out_index),
`ifdef ARGMAX_TOP2_EN
        .out_value2(u_out_value2), .out_index2(u_out_index2),
`endif
        .out_err(u_out_err)
    );

    argmax_stream #(.N_CLASS(N), .DATA_W(W), .SIGNED_CMP(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_value(s_out_value), .out_index(s_out_index),
`ifdef ARGMAX_TOP2_EN
        .out_value2(s_out_value2), .out_index2(s_out_index2),
`endif
        .out_err(s_out_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit gtb(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        if (sgn) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // Winner = first occurrence of the largest score; runner-up = best of the rest,
    // starting from the minimum representable value at index 0.
    task automatic model(input frame_t sc, input int len, input bit sgn,
                         output logic [W-1:0] v, output int ix,
                         output logic [W-1:0] v2, output int ix2);
        v  = sc[0];
        ix = 0;
        for (int j = 1; j < len; j++) begin
            if (gtb(sc[j], v, sgn)) begin
                v  = sc[j];
                ix = j;
            end
        end
        v2  = sgn ? 16'h8000 : 16'h0000;
        ix2 = 0;
        for (int j = 0; j < len; j++) begin
            if (j != ix && gtb(sc[j], v2, sgn)) begin
                v2  = sc[j];
                ix2 = j;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] eu, input int iu,
                                input logic [W-1:0] es, input int is_, input bit ee,
                                input logic [W-1:0] eu2, input int iu2,
                                input logic [W-1:0] es2, input int is2);
        chk({tag, ".u_valid"}, u_out_valid, 1);
        chk({tag, ".u_value"}, u_out_value, eu);
        chk({tag, ".u_index"}, u_out_index, iu);
        chk({tag, ".u_err"},   u_out_err, ee);
        chk({tag, ".u_ready"}, u_in_ready, 0);
        chk({tag, ".s_valid"}, s_out_valid, 1);
        chk({tag, ".s_value"}, s_out_value, es);
        chk({tag, ".s_index"}, s_out_index, is_);
        chk({tag, ".s_err"},   s_out_err, ee);
        chk({tag, ".s_ready"}, s_in_ready, 0);
`ifdef ARGMAX_TOP2_EN
        chk({tag, ".u_value2"}, u_out_value2, eu2);
        chk({tag, ".u_index2"}, u_out_index2, iu2);
        chk({tag, ".s_value2"}, s_out_value2, es2);
        chk({tag, ".s_index2"}, s_out_index2, is2);
`else
        if (eu2 === 16'hxxxx && iu2 < 0 && es2 === 16'hxxxx && is2 < 0) $display("unreachable");
`endif
    endtask

    // Called just after a falling edge with the block idle in the accept state.
    task automatic run_frame(input string tag, input frame_t sc, input int len, input bit last,
                             input int hold, input bit gaps, input bit ack,
                             input logic [W-1:0] eu, input int iu,
                             input logic [W-1:0] es, input int is_, input bit ee);
        logic [W-1:0] mv, mu2, ms2;
        int           mi, miu2, mis2;
        model(sc, len, 1'b0, mv, mi, mu2, miu2);
        model(sc, len, 1'b1, mv, mi, ms2, mis2);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                in_last  = 1'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = sc[i];
            in_last  = last && (i == len - 1);
            chk({tag, ".beat_ready_u"}, u_in_ready, 1);
            chk({tag, ".beat_ready_s"}, s_in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = W'($urandom);
        check_result(tag, eu, iu, es, is_, ee, mu2, miu2, ms2, mis2);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_result({tag, ".hold"}, eu, iu, es, is_, ee, mu2, miu2, ms2, mis2);
        end
        if (ack) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({tag, ".ack_valid_u"}, u_out_valid, 0);
            chk({tag, ".ack_valid_s"}, s_out_valid, 0);
            chk({tag, ".ack_ready_u"}, u_in_ready, 1);
            chk({tag, ".ack_ready_s"}, s_in_ready, 1);
        end
    endtask

    function automatic frame_t flat(input logic [W-1:0] v);
        frame_t r;
        for (int i = 0; i < N; i++) r[i] = v;
        return r;
    endfunction

    vec_t tbl[10];

    initial begin
        frame_t       f;
        logic [W-1:0] eu, es, d2;
        int           iu, is_, di2, len;
        bit           last;

        f = flat(16'h0100); f[7] = 16'h0500;
        tbl[0] = '{f, 10, 1'b1, 0, 16'h0500, 7, 16'h0500, 7, 1'b0};
        f = flat(16'h0000); f[2] = 16'h7FFF; f[5] = 16'h7FFF;
        tbl[1] = '{f, 10, 1'b1, 0, 16'h7FFF, 2, 16'h7FFF, 2, 1'b0};
        f = flat(16'h8000); f[0] = 16'hFFFF; f[1] = 16'h0001;
        tbl[2] = '{f, 10, 1'b1, 5, 16'hFFFF, 0, 16'h0001, 1, 1'b0};
        f = flat(16'h0000); f[0] = 16'd1; f[1] = 16'd9; f[2] = 16'd4; f[3] = 16'd2;
        tbl[3] = '{f, 4, 1'b1, 0, 16'd9, 1, 16'd9, 1, 1'b1};
        f = flat(16'h0011); f[4] = 16'h0042;
        tbl[4] = '{f, 10, 1'b0, 1, 16'h0042, 4, 16'h0042, 4, 1'b1};
        f = flat(16'h0000); f[0] = 16'h1234;
        tbl[5] = '{f, 1, 1'b1, 0, 16'h1234, 0, 16'h1234, 0, 1'b1};
        f = flat(16'h0033);
        tbl[6] = '{f, 10, 1'b1, 0, 16'h0033, 0, 16'h0033, 0, 1'b0};
        f = flat(16'h0001); f[9] = 16'h00AA;
        tbl[7] = '{f, 10, 1'b1, 2, 16'h00AA, 9, 16'h00AA, 9, 1'b0};
        f = flat(16'h0001); f[0] = 16'd3; f[1] = 16'd8; f[2] = 16'd5; f[9] = 16'd2;
        tbl[8] = '{f, 10, 1'b1, 0, 16'd8, 1, 16'd8, 1, 1'b0};
        f = flat(16'hFF00); f[3] = 16'hFFF0; f[6] = 16'h0000;
        tbl[9] = '{f, 10, 1'b1, 0, 16'hFFF0, 3, 16'h0000, 6, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst.ready_u", u_in_ready, 0);
        chk("rst.ready_s", s_in_ready, 0);
        chk("rst.valid_u", u_out_valid, 0);
        chk("rst.value_u", u_out_value, 0);
        chk("rst.index_u", u_out_index, 0);
        chk("rst.err_u",   u_out_err, 0);
        chk("rst.valid_s", s_out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.ready_u", u_in_ready, 1);

        for (int k = 0; k < 10; k++) begin
            run_frame($sformatf("tbl%0d", k), tbl[k].sc, tbl[k].len, tbl[k].last, tbl[k].hold,
                      1'b0, 1'b1, tbl[k].eu, tbl[k].iu, tbl[k].es, tbl[k].is_, tbl[k].ee);
        end

        // Reset after five beats discards the partial frame.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'h7000; in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.ready_u", u_in_ready, 0);
        chk("midrst.valid_u", u_out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst.ready_after", u_in_ready, 1);
        f = flat(16'h0100); f[0] = 16'h0400;
        run_frame("midrst.frame", f, 10, 1'b1, 0, 1'b0, 1'b1, 16'h0400, 0, 16'h0400, 0, 1'b0);

        // Reset while a result is pending drops it.
        f = flat(16'h0002); f[5] = 16'h0009;
        run_frame("outrst.frame", f, 10, 1'b1, 1, 1'b0, 1'b0, 16'h0009, 5, 16'h0009, 5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("outrst.valid_u", u_out_valid, 0);
        chk("outrst.valid_s", s_out_valid, 0);
        @(negedge clk);
        chk("outrst.ready_u", u_in_ready, 1);

        for (int r = 0; r < 40; r++) begin
            int mode;
            len  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, N - 1) : N;
            last = (len < N) ? 1'b1 : 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 2);
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0: f[i] = W'($urandom);
                    1: f[i] = W'($urandom_range(0, 3));
                    default: begin
                        case ($urandom_range(0, 3))
                            0: f[i] = 16'h8000;
                            1: f[i] = 16'h7FFF;
                            2: f[i] = 16'hFFFF;
                            default: f[i] = 16'h0000;
                        endcase
                    end
                endcase
            end
            model(f, len, 1'b0, eu, iu, d2, di2);
            model(f, len, 1'b1, es, is_, d2, di2);
            run_frame($sformatf("rnd%0d", r), f, len, last, $urandom_range(0, 2), 1'b1, 1'b1,
                      eu, iu, es, is_, (len != N) || !last);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/argmax_stream.md
Name: argmax_stream

Overview:
- Parametrised successor to the fixed 10-class max/index selector at the end of the FC layer.
- Accepts one class score per cycle over a valid/ready stream and tracks the running maximum and its index.
- Emits the winning class through an output valid/ready handshake.
- Class count, data width and signedness are generics, and frame-length errors are flagged.

Parameters:
- N_CLASS, 10, number of scores per frame (>=2)
- DATA_W, 16, score width in bits
- SIGNED_CMP, 0, 1 = two's-complement compare, 0 = unsigned compare
- IDX_W (localparam), $clog2(N_CLASS), index width

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  score beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  DATA_W  class score; class index is implied by beat order
- in_last  in  1  marks the final beat of a frame
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_value  out  DATA_W  maximum score
- out_index  out  IDX_W  index of the maximum score
- out_err  out  1  frame length was not N_CLASS

Behaviour:
- Single clock. Reset is synchronous and active-high; clock and reset are named clk and rst.
- Reset values: state=S_ACC, cnt=0, out_valid=0, out_value=0, out_index=0, out_err=0.
- in_ready=0 while rst=1. Outside reset, in_ready=1 exactly when state==S_ACC.
- States:
  - S_ACC: accepting beats.
  - S_OUT: holding the result.
- Beat accept is in_valid && in_ready.
  - When cnt==0, load max=in_data and idx=0.
  - Otherwise, replace max/idx only if in_data is strictly greater than max.
  - Strict compare means ties resolve to the lowest index.
  - cnt increments on every accept.
- A frame ends on an accepted beat with in_last=1, or with cnt==N_CLASS-1. On that beat:
  - The final compare includes the current beat.
  - The result registers into out_value/out_index.
  - out_err = (in_last XOR (cnt==N_CLASS-1)). This covers both a short frame and a missing in_last.
  - out_valid goes to 1 and state moves to S_OUT.
- Latency: out_valid rises on the cycle after the final beat's accept edge.
- S_OUT:
  - in_ready=0. No overlap with the next frame; throughput is N_CLASS+1 cycles per frame at best.
  - out_value, out_index and out_err stay stable while out_valid=1 and out_ready=0.
- On out_valid && out_ready: out_valid=0, cnt=0, state moves to S_ACC. in_ready=1 on the next cycle.
- in_data is ignored when in_valid=0.
- in_last on the first beat gives a 1-score frame: out_index=0 and out_err=1.
- Compare uses $signed when SIGNED_CMP=1 and unsigned otherwise. There is no width growth.
- Reset mid-frame discards the partial frame. Reset in S_OUT drops the pending result.

Optional Feature:
- Macro: ARGMAX_TOP2_EN.
- When defined, add output ports out_value2 [DATA_W] and out_index2 [IDX_W] carrying the second-highest score and its index.
  - On a new maximum, the old max moves to second.
  - Otherwise second updates on strictly greater than second.
  - Beat 0 initialises second to the minimum representable value with index 0.
  - Reset value is 0.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package argmax_pkg holds:
  - the state enum {S_ACC, S_OUT};
  - a function gt(a, b, signed_mode) returning the strict-greater compare;
  - the minimum-value constant helper.
- One sub-module, argmax_cmp_upd: a combinational compare/update cell (current max/idx plus beat gives next max/idx). It is instanced once, or twice with ARGMAX_TOP2_EN.

Test Plan (defaults unless stated):
- Scores 0x0100 for all beats except beat 7=0x0500; in_last on beat 9; out_ready=1 -> out_valid 1 cycle after the 10th accept, out_index=7, out_value=0x0500, out_err=0.
- Beats 2 and 5 = 0x7FFF, others 0x0000 -> out_index=2.
- Beat 0=0xFFFF, beat 1=0x0001, others 0x8000:
  - SIGNED_CMP=1 -> index 1, value 0x0001.
  - SIGNED_CMP=0 -> index 0, value 0xFFFF.
- Hold out_ready=0 for 5 cycles after a result -> out_valid and result held stable, in_ready=0. Raise out_ready -> in_ready=1 the next cycle, and the next frame gives an independent correct result.
- Frame-length errors:
  - in_last on beat 3 with scores 1,9,4,2 -> index 1, value 9, out_err=1.
  - 10 beats with no in_last -> result emitted with out_err=1.
- Reset asserted after 5 beats, then a full frame with max at beat 0 -> out_index=0. With ARGMAX_TOP2_EN, scores 3,8,5,… -> out_index2=2 and out_value2=5 when 5 is the second highest.
